lsu_mem_master: RTL

- Load/store initiator that drives the word-addressed data memory: combinational read, write on the rising clk edge when the write enable is high.
- Accepts one RV32I load/store request at a time from the MEM stage.
- Converts byte addresses to word indices and performs byte/halfword extraction with sign or zero extension.
- Implements SB/SH as a read-modify-write, because the memory supports only whole-word writes.

---
 rtl/lsu_mem_master.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: RV32I load/store initiator for a word-addressed memory with
// combinational read; sub-word stores are done as read-modify-write.
`default_nettype none

module lsu_mem_master #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      RMW  = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t      state, state_n;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wd_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        f3_legal;
   logic        misaligned;
   logic        out_of_range;
   logic        req_err;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_ext;
   logic [31:0] merged;

   // Request qualification, evaluated on the raw inputs at acceptance.
   always_comb begin
      f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                 (req_funct3 == 3'b010) ||
                 (!req_store && ((req_funct3 == 3'b100) || (req_funct3 == 3'b101)));
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
      req_err = !f3_legal || misaligned || out_of_range;
   end

   always_comb begin
      lane_byte = mem_rd[{addr_q[1:0], 3'b000} +: 8];
      lane_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
         3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
         3'b100:  load_ext = {24'h0, lane_byte};
         3'b101:  load_ext = {16'h0, lane_half};
         default: load_ext = mem_rd;
      endcase
   end

   always_comb begin
      merged = mem_rd;
      if (f3_q[1:0] == 2'b00) begin
         merged[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
      end else if (f3_q[1:0] == 2'b01) begin
         if (addr_q[1]) merged[31:16] = wd_q[15:0];
         else           merged[15:0]  = wd_q[15:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_err)                       state_n = RESP;
               else if (!req_store)               state_n = RD;
               else if (req_funct3[1:0] == 2'b10) state_n = WR;
               else                               state_n = RMW;
            end
         end
         RD:      state_n = RESP;
         RMW:     state_n = WR;
         WR:      state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f3_q    <= 3'b000;
         addr_q  <= 32'h0;
         wd_q    <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr;
                  wd_q    <= req_wdata;
                  rdata_q <= 32'h0;
                  err_q   <= req_err;
               end
            end
            RD:      rdata_q <= load_ext;
            RMW:     wd_q    <= merged;
            default: ;
         endcase
      end
   end

   // All outputs are decoded from state so request inputs never reach mem_we.
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_rdata = (state == RESP) ? rdata_q : 32'h0;
   assign resp_err   = (state == RESP) && err_q;
   assign mem_we     = (state == WR);
   assign mem_wd     = (state == WR) ? wd_q : 32'h0;
   assign mem_a      = {2'b00, addr_q[31:2]};

endmodule

`default_nettype wire
